writeback_commit_buffer: RTL
============================

Name: writeback_commit_buffer

Overview:
Parametrised writeback stage with an in-order retirement buffer between the memory stage and the register file / commit interface. Accepts one completed instruction per cycle via valid/ready and retires up to COMMIT_WIDTH oldest entries per cycle. Each retiring entry produces a register-file write lane and a commit record. Provides youngest-writer forwarding for two source registers across all buffered and incoming entries.

Parameters:
XLEN, 64, data/PC width
DEPTH, 4, buffer entries; power of two, >= 2
COMMIT_WIDTH, 2, max entries retired per cycle; 1 <= COMMIT_WIDTH <= DEPTH

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  memory stage offers an entry
in_ready  out  1  buffer can accept this cycle
in_inst  in  32  instruction word; rd = in_inst[11:7]
in_pc  in  XLEN  instruction PC
in_value  in  XLEN  result to write
in_wen  in  1  instruction writes rd
in_jump  in  1  instruction redirected control flow
commit_hold  in  1  suppress retirement this cycle
rf_we  out  COMMIT_WIDTH  per-lane regfile write enable
rf_waddr  out  5*COMMIT_WIDTH  per-lane rd
rf_wdata  out  XLEN*COMMIT_WIDTH  per-lane data
commit_valid  out  COMMIT_WIDTH  per-lane retire strobe; lane 0 oldest
commit_inst  out  32*COMMIT_WIDTH  retired instruction words
commit_pc  out  XLEN*COMMIT_WIDTH  retired PCs
commit_jump  out  COMMIT_WIDTH  retired jump flags
fwd_raddr  in  5*2  query regs (rs1, rs2)
fwd_hit  out  2  per-query match
fwd_data  out  XLEN*2  per-query youngest matching value
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Storage: circular buffer; head/tail pointers with one extra wrap bit; full = pointers equal except wrap bit; empty = fully equal.
- Reset (edge with reset=1): head=tail=0, count=0, all entry valid bits cleared. While reset is high: in_ready=0, and all commit_valid, rf_we, and fwd_hit = 0.
- in_ready = !full. No same-cycle enqueue-on-full, even if a retirement is occurring.
- Enqueue on in_valid && in_ready at the edge; the entry sits at tail, then tail advances by 1.
- Retire count n = commit_hold ? 0 : min(count, COMMIT_WIDTH). Lanes 0..n-1 present entries head..head+n-1 combinationally from storage. commit_valid[i] = (i < n). Head advances by n at the edge.
- Latency: entry accepted at edge t appears on commit lane 0 in cycle t+1 if the buffer was otherwise empty. No input-to-output combinational path on commit outputs.
- Simultaneous enqueue and retire: count_next = count + enq - n. Pointers wrap modulo DEPTH.
- rf_we[i] = commit_valid[i] && wen && rd != 0.
- Same rd on two retiring lanes: the older lane's rf_we is suppressed, so only the youngest write reaches the regfile. commit_valid is unaffected.
- Forwarding, for each query q with fwd_raddr[q] != 0:
  - Candidates are all buffered valid entries with wen && rd == query, plus the incoming entry if in_valid && in_ready.
  - Priority is youngest first, with the incoming entry youngest of all.
  - Entries retiring this cycle remain candidates.
  - Query 0 never hits.
- commit_hold with a full buffer: in_ready stays 0, nothing retires, and state is frozen.
- Reset asserted mid-operation discards all buffered entries without asserting rf_we.

Optional Feature:
WB_RETIRE_COUNTER_EN:
- When defined, adds output retired_count (64 bits), reset to 0 and incremented by n every edge.
- Adds output retire_stall_cycles (32 bits), incremented on each edge where commit_hold=1 and count>0.
- When undefined, neither port nor its logic exists, and all other behaviour is identical.

Test Plan:
- Single entry: reset, then in_valid=1, in_inst rd=5, in_value=0xDEAD, in_wen=1 for one cycle -> next cycle commit_valid=2'b01, rf_we[0]=1, rf_waddr[0]=5, rf_wdata[0]=0xDEAD; count returns to 0 the following cycle.
- x0 suppression: entry rd=0, in_wen=1, value 0x1234 -> commit_valid[0]=1, rf_we[0]=0; forward query reg 0 -> fwd_hit=0.
- Fill and stall: commit_hold=1, enqueue 4 entries (PC 0x100..0x10C) -> count=4, in_ready=0. Release hold -> cycle 1 retires PCs 0x100,0x104 on lanes 0,1; cycle 2 retires 0x108,0x10C; in_ready=1 after the first retire edge.
- Same-rd collision: two buffered entries rd=7, values 1 then 2, retiring together -> rf_we=2'b10, rf_wdata[1]=2, commit_valid=2'b11.
- Forwarding priority: buffered rd=3 value 0xA, incoming in_valid rd=3 value 0xB, fwd_raddr[0]=3 -> fwd_hit[0]=1, fwd_data[0]=0xB. With in_valid=0 -> 0xA.
- Reset mid-run: 3 entries buffered, assert reset for 1 cycle -> count=0, no rf_we during or after reset, in_ready=0 during reset and 1 the cycle after. With WB_RETIRE_COUNTER_EN, retired_count=0.

Source files
------------

// File: rtl/writeback_commit_buffer_if.sv
// Writeback/commit bus: memory-stage enqueue handshake, regfile write lanes,
// commit records, forwarding queries and occupancy.
// Optional macro WB_RETIRE_COUNTER_EN adds retired_count / retire_stall_cycles.
interface writeback_commit_buffer_if #(
   parameter int XLEN         = 64,
   parameter int DEPTH        = 4,
   parameter int COMMIT_WIDTH = 2
);
   logic                                in_valid;
   logic                                in_ready;
   logic [31:0]                         in_inst;
   logic [XLEN-1:0]                     in_pc;
   logic [XLEN-1:0]                     in_value;
   logic                                in_wen;
   logic                                in_jump;
   logic                                commit_hold;
   logic [COMMIT_WIDTH-1:0]             rf_we;
   logic [COMMIT_WIDTH-1:0][4:0]        rf_waddr;
   logic [COMMIT_WIDTH-1:0][XLEN-1:0]   rf_wdata;
   logic [COMMIT_WIDTH-1:0]             commit_valid;
   logic [COMMIT_WIDTH-1:0][31:0]       commit_inst;
   logic [COMMIT_WIDTH-1:0][XLEN-1:0]   commit_pc;
   logic [COMMIT_WIDTH-1:0]             commit_jump;
   logic [1:0][4:0]                     fwd_raddr;
   logic [1:0]                          fwd_hit;
   logic [1:0][XLEN-1:0]                fwd_data;
   logic [$clog2(DEPTH):0]              count;
`ifdef WB_RETIRE_COUNTER_EN
   logic [63:0]                         retired_count;
   logic [31:0]                         retire_stall_cycles;
`endif

   // environment side: drives the memory stage, hold and queries
   modport master (
      output in_valid, in_inst, in_pc, in_value, in_wen, in_jump,
      output commit_hold, fwd_raddr,
      input  in_ready, rf_we, rf_waddr, rf_wdata,
      input  commit_valid, commit_inst, commit_pc, commit_jump,
      input  fwd_hit, fwd_data,
`ifdef WB_RETIRE_COUNTER_EN
      input  retired_count, retire_stall_cycles,
`endif
      input  count
   );

   // buffer side
   modport slave (
      input  in_valid, in_inst, in_pc, in_value, in_wen, in_jump,
      input  commit_hold, fwd_raddr,
      output in_ready, rf_we, rf_waddr, rf_wdata,
      output commit_valid, commit_inst, commit_pc, commit_jump,
      output fwd_hit, fwd_data,
`ifdef WB_RETIRE_COUNTER_EN
      output retired_count, retire_stall_cycles,
`endif
      output count
   );
endinterface

// File: rtl/writeback_commit_buffer.sv
// In-order writeback/retirement buffer. One entry enqueued per cycle, up to
// COMMIT_WIDTH oldest entries retired per cycle, youngest-writer forwarding
// for two source registers over buffered and incoming entries.
// Optional macro WB_RETIRE_COUNTER_EN adds retirement and stall counters.
module writeback_commit_buffer #(
   parameter int XLEN         = 64,
   parameter int DEPTH        = 4,
   parameter int COMMIT_WIDTH = 2
) (
   input logic                       clk,
   input logic                       reset,
   writeback_commit_buffer_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CB = PW + 1;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] value;
      logic            wen;
      logic            jump;
   } entry_t;

   entry_t                           mem [DEPTH];
   logic [DEPTH-1:0]                 e_vld;
   logic [CB-1:0]                    head, tail, occ, n_ret;
   logic                             full, enq;
   logic [COMMIT_WIDTH-1:0][PW-1:0]  lane_idx;
   logic [COMMIT_WIDTH-1:0][4:0]     lane_rd;
   logic [COMMIT_WIDTH-1:0]          lane_wen, lane_live, rf_we_c;
   logic [1:0]                       fwd_hit_c;
   logic [1:0][XLEN-1:0]             fwd_data_c;

   // occupancy from wrap-bit pointers; full when only the wrap bit differs
   assign occ  = tail - head;
   assign full = (head[PW] != tail[PW]) && (head[PW-1:0] == tail[PW-1:0]);
   assign bus.in_ready = !full && !reset;
   assign enq  = bus.in_valid && bus.in_ready;
   assign bus.count = occ;

   // retire count: min(occupancy, COMMIT_WIDTH) unless held or in reset
   always_comb begin
      n_ret = '0;
      if (!reset && !bus.commit_hold)
         n_ret = (occ > CB'(COMMIT_WIDTH)) ? CB'(COMMIT_WIDTH) : occ;
   end

   // commit lanes read straight from storage, lane 0 = head (oldest)
   for (genvar i = 0; i < COMMIT_WIDTH; i++) begin : g_lane
      entry_t ent;
      assign lane_idx[i]          = head[PW-1:0] + PW'(i);
      assign ent                  = mem[lane_idx[i]];
      assign lane_live[i]         = n_ret > CB'(i);
      assign lane_rd[i]           = ent.inst[11:7];
      assign lane_wen[i]          = ent.wen;
      assign bus.commit_valid[i]  = lane_live[i];
      assign bus.commit_inst[i]   = ent.inst;
      assign bus.commit_pc[i]     = ent.pc;
      assign bus.commit_jump[i]   = ent.jump;
      assign bus.rf_waddr[i]      = ent.inst[11:7];
      assign bus.rf_wdata[i]      = ent.value;
   end

   // regfile write enables; an older lane yields to a younger lane writing the same rd
   always_comb begin
      rf_we_c = '0;
      for (int i = 0; i < COMMIT_WIDTH; i++) begin
         rf_we_c[i] = lane_live[i] && lane_wen[i] && (lane_rd[i] != 5'd0);
         for (int j = 0; j < COMMIT_WIDTH; j++)
            if (j > i && lane_live[j] && lane_wen[j] && lane_rd[j] == lane_rd[i])
               rf_we_c[i] = 1'b0;
      end
   end
   assign bus.rf_we = rf_we_c;

   // forwarding: scan oldest to youngest so the last match wins, incoming entry last
   always_comb begin
      logic [PW-1:0] idx;
      idx        = '0;
      fwd_hit_c  = '0;
      fwd_data_c = '0;
      if (!reset) begin
         for (int q = 0; q < 2; q++) begin
            if (bus.fwd_raddr[q] != 5'd0) begin
               for (int k = 0; k < DEPTH; k++) begin
                  idx = head[PW-1:0] + PW'(k);
                  if (CB'(k) < occ && e_vld[idx] && mem[idx].wen &&
                      mem[idx].inst[11:7] == bus.fwd_raddr[q]) begin
                     fwd_hit_c[q]  = 1'b1;
                     fwd_data_c[q] = mem[idx].value;
                  end
               end
               if (enq && bus.in_wen && bus.in_inst[11:7] == bus.fwd_raddr[q]) begin
                  fwd_hit_c[q]  = 1'b1;
                  fwd_data_c[q] = bus.in_value;
               end
            end
         end
      end
   end
   assign bus.fwd_hit  = fwd_hit_c;
   assign bus.fwd_data = fwd_data_c;

   // pointers and entry valid bits; retiring slots never alias the tail slot (no enqueue when full)
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         e_vld <= '0;
      end else begin
         for (int i = 0; i < COMMIT_WIDTH; i++)
            if (lane_live[i]) e_vld[lane_idx[i]] <= 1'b0;
         if (enq) begin
            e_vld[tail[PW-1:0]] <= 1'b1;
            tail <= tail + CB'(1);
         end
         head <= head + n_ret;
      end
   end

   // entry payload storage, written at tail on enqueue
   always_ff @(posedge clk) begin
      if (enq)
         mem[tail[PW-1:0]] <= '{inst: bus.in_inst, pc: bus.in_pc, value: bus.in_value,
                                wen: bus.in_wen, jump: bus.in_jump};
   end

`ifdef WB_RETIRE_COUNTER_EN
   logic [63:0] retired_q;
   logic [31:0] stall_q;

   // retirement total and cycles where hold blocked a non-empty buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         retired_q <= retired_q + 64'(n_ret);
         if (bus.commit_hold && occ != '0) stall_q <= stall_q + 32'd1;
      end
   end
   assign bus.retired_count       = retired_q;
   assign bus.retire_stall_cycles = stall_q;
`endif
endmodule
